alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have clk  input  1  rising-edge clock; the block's one clock.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have in_valid  input  1  high when A, B and Op carry an operation this cycle.
REQ-005 SHALL have A  input  WIDTH  operand A, unsigned/two's-complement.
REQ-006 SHALL have B  input  WIDTH  operand B.
REQ-007 SHALL have Op  input  3  operation select.
REQ-008 SHALL have R  output  WIDTH  registered result.
REQ-009 SHALL have out_valid  output  1  high for one cycle when R/flags hold a new result.
REQ-010 SHALL have carry, zero, negative, overflow  output  1 each  registered status flags for R.

Function
REQ-011 SHALL decode Op: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHL A by 1, zero-fill; 7 SHR A by 1 (logical), zero-fill.
REQ-012 SHALL register the result: an operation accepted at edge N appears on R/flags after edge N, out_valid high until edge N+1 (latency 1).
REQ-013 SHALL hold R and all flags unchanged while in_valid is low; out_valid SHALL be low on the next cycle.
REQ-014 SHALL accept a new operation every cycle (no backpressure); back-to-back in_valid yields back-to-back out_valid.
REQ-015 ADD: R = (A+B) mod 2^WIDTH; carry = bit WIDTH of the unsigned sum; overflow = operands same sign and result sign differs.
REQ-016 SUB: R = (A-B) mod 2^WIDTH; carry = borrow (1 when A < B unsigned); overflow = operands differ in sign and result sign differs from A.
REQ-017 AND/OR/XOR/NOT: carry = 0, overflow = 0.
REQ-018 SHL: carry = A[WIDTH-1]; SHR: carry = A[0]; overflow = 0 for both.
REQ-019 zero = 1 iff R == 0; negative = R[WIDTH-1]; both for every Op.
REQ-020 Boundary: 0xFF+0x01 -> R=0x00, carry=1, zero=1, overflow=0; 0x7F+0x01 -> R=0x80, overflow=1, negative=1.
REQ-021 Boundary: 0x00-0x01 -> R=0xFF, carry=1, negative=1; 0x80-0x01 -> R=0x7F, overflow=1.
REQ-022 Result SHALL be purely a function of the inputs sampled at the accepting edge; no state carries between operations other than held outputs.

Reset
REQ-023 SHALL, while rst_n is low, force R=0, carry=0, zero=0, negative=0, overflow=0, out_valid=0 immediately, independent of clk.
REQ-024 SHALL discard an operation whose accepting edge coincides with rst_n low; first result after release requires in_valid at a rising edge with rst_n high.
REQ-025 SHALL not produce out_valid on the first cycle after rst_n deasserts unless in_valid was high at that edge.

Structure
REQ-026 SHALL place the 3-bit opcode constants (OP_ADD..OP_SHR) and flag-bundle typedef in shared package alu_pkg.
REQ-027 SHALL split into a combinational sub-module alu_core (A, B, Op -> next result and flags) and the registering top alu.
REQ-028 SHALL compute arithmetic in a WIDTH+1-bit intermediate to extract carry/borrow.

Verification
REQ-029 Reset: rst_n low mid-operation with in_valid=1 -> all outputs 0 asynchronously, out_valid=0.
REQ-030 Sweep A=0x6A, B=0x3B, Op 0..7 one per cycle -> R = 0xA5 (overflow=1, negative=1), 0x2F, 0x2A, 0x7B, 0x51, 0x95, 0xD4 (carry=0), 0x35 (carry=0), each one cycle after issue.
REQ-031 Carry/zero: Op=0, A=0xFF, B=0x01 -> R=0x00, carry=1, zero=1.
REQ-032 Signed overflow: Op=1, A=0x80, B=0x01 -> R=0x7F, overflow=1, negative=0; Op=0, A=0x7F, B=0x01 -> R=0x80, overflow=1.
REQ-033 Shifts: Op=6, A=0x81 -> R=0x02, carry=1; Op=7, A=0x81 -> R=0x40, carry=1.
REQ-034 Hold: in_valid deasserted after a result -> R and flags unchanged, out_valid=0 for every idle cycle.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode encodings and status-flag bundle shared by the ALU
//                core and its registering wrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // 3-bit operation select encodings
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    // Status flags that accompany every result
    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

    localparam alu_flags_t c_FLAGS_CLEAR = '{carry: 1'b0, zero: 1'b0, negative: 1'b0, overflow: 1'b0};

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational datapath: computes the result and
//                status flags for one operation from A, B and Op.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    // Arithmetic is done one bit wider so bit WIDTH holds carry-out or borrow.
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};

    // Select result, carry and signed overflow for the requested operation
    always_comb begin
        result         = '0;
        flags          = c_FLAGS_CLEAR;
        case (Op)
            OP_ADD: begin
                result         = w_sum[WIDTH-1:0];
                flags.carry    = w_sum[WIDTH];
                // Same-sign operands producing a different-sign result
                flags.overflow = (A[WIDTH-1] == B[WIDTH-1]) &&
                                 (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                result         = w_diff[WIDTH-1:0];
                flags.carry    = w_diff[WIDTH];
                // Opposite-sign operands and the result sign departs from A
                flags.overflow = (A[WIDTH-1] != B[WIDTH-1]) &&
                                 (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: result = A & B;
            OP_OR:  result = A | B;
            OP_XOR: result = A ^ B;
            OP_NOT: result = ~A;
            OP_SHL: begin
                result      = {A[WIDTH-2:0], 1'b0};
                flags.carry = A[WIDTH-1];
            end
            OP_SHR: begin
                result      = {1'b0, A[WIDTH-1:1]};
                flags.carry = A[0];
            end
            default: begin
                result = '0;
                flags  = c_FLAGS_CLEAR;
            end
        endcase
        flags.zero     = (result == '0);
        flags.negative = result[WIDTH-1];
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Single-cycle-latency ALU. Accepts one operation per cycle
//                when in_valid is high and presents the registered result and
//                flags on the following cycle with a one-cycle out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    output logic [WIDTH-1:0] R,
    output logic             out_valid,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    logic [WIDTH-1:0] w_result;
    alu_flags_t       w_flags;

    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;
    logic             r_out_valid;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A      (A),
        .B      (B),
        .Op     (Op),
        .result (w_result),
        .flags  (w_flags)
    );

    // Capture result and flags on accepted operations; otherwise hold them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_flags     <= c_FLAGS_CLEAR;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
        end
    end

    assign R         = r_result;
    assign out_valid = r_out_valid;
    assign carry     = r_flags.carry;
    assign zero      = r_flags.zero;
    assign negative  = r_flags.negative;
    assign overflow  = r_flags.overflow;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu
//  Description : Directed, table-driven self-checking bench for alu.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       Op;
    logic [WIDTH-1:0] R;
    logic             out_valid;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;

    int checks;
    int errors;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             z;
        logic             n;
        logic             v;
    } vec_t;

    vec_t vecs [16];

    alu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .R         (R),
        .out_valid (out_valid),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] r_e, input logic c_e,
                             input logic z_e, input logic n_e, input logic v_e, input logic ov_e);
        check({tag, ".R"},         32'(R),         32'(r_e));
        check({tag, ".carry"},     32'(carry),     32'(c_e));
        check({tag, ".zero"},      32'(zero),      32'(z_e));
        check({tag, ".negative"},  32'(negative),  32'(n_e));
        check({tag, ".overflow"},  32'(overflow),  32'(v_e));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov_e));
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Op       = '0;

        //               op    a      b      r      c     z     n     v
        vecs[0]  = '{3'd0, 8'h6A, 8'h3B, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{3'd1, 8'h6A, 8'h3B, 8'h2F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'd2, 8'h6A, 8'h3B, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd3, 8'h6A, 8'h3B, 8'h7B, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'd4, 8'h6A, 8'h3B, 8'h51, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'd5, 8'h6A, 8'h3B, 8'h95, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{3'd6, 8'h6A, 8'h3B, 8'hD4, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'd7, 8'h6A, 8'h3B, 8'h35, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{3'd1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'd6, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'd7, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'd2, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{3'd1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state
        #1;
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Release with in_valid low: no out_valid on the first cycle
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back table vectors, each result checked one cycle after issue
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            Op       = vecs[i].op;
            A        = vecs[i].a;
            B        = vecs[i].b;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].z,
                      vecs[i].n, vecs[i].v, 1'b1);
        end

        // Hold: idle cycles keep last result (vec15: R=0, zero=1), out_valid low
        @(negedge clk);
        in_valid = 1'b0;
        Op       = 3'd0;
        A        = 8'hFF;
        B        = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("hold%0d", k), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Hold after a non-zero result with flags set
        @(negedge clk);
        in_valid = 1'b1;
        Op       = 3'd0;
        A        = 8'h7F;
        B        = 8'h01;
        @(posedge clk);
        #1;
        check_all("pre_hold", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        A        = 8'h00;
        B        = 8'h00;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("hold_b%0d", k), 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end

        // Asynchronous reset mid-operation with in_valid high
        @(negedge clk);
        in_valid = 1'b1;
        Op       = 3'd5;
        A        = 8'h00;
        @(posedge clk);
        #1;
        check_all("pre_async", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // An edge while reset is held must not accept the pending operation
        @(posedge clk);
        #1;
        check_all("reset_edge_discard", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Release with in_valid low, then confirm nothing appears
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check_all("release_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // First operation after release
        @(negedge clk);
        in_valid = 1'b1;
        Op       = 3'd4;
        A        = 8'hAA;
        B        = 8'h55;
        @(posedge clk);
        #1;
        check_all("first_after_release", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("final_idle", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire
